// File: rtl/fir_pkg.sv
// fir_pkg: shared types and arithmetic helpers for fir_decim_mc.
//   fir_state_t : control FSM states (FILL, MAC, WRITE)
//   mul_frac()  : signed product arithmetic-shifted right by the fraction width
//   sat()       : clamp a wide signed value into a w-bit signed range
// Helpers work on fixed wide operands: DATA_WIDTH and COEFF_WIDTH must be <= 64,
// and the accumulator width must be <= 128.
package fir_pkg;

    typedef enum logic [1:0] {FILL, MAC, WRITE} fir_state_t;

    localparam int unsigned FIR_OPND_W = 64;
    localparam int unsigned FIR_MAX_W  = 128;

    function automatic logic signed [FIR_MAX_W-1:0] mul_frac(
        input logic signed [FIR_OPND_W-1:0] a,
        input logic signed [FIR_OPND_W-1:0] b,
        input int unsigned                  frac
    );
        logic signed [FIR_MAX_W-1:0] p;
        p = FIR_MAX_W'(a) * FIR_MAX_W'(b);
        return p >>> frac;
    endfunction

    function automatic logic signed [FIR_MAX_W-1:0] sat(
        input logic signed [FIR_MAX_W-1:0] v,
        input int unsigned                 w
    );
        logic signed [FIR_MAX_W-1:0] hi;
        logic signed [FIR_MAX_W-1:0] lo;
        hi = $signed((FIR_MAX_W'(1) << (w - 1)) - FIR_MAX_W'(1));
        lo = -hi - FIR_MAX_W'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// fir_mac_lane: one channel's multiply-accumulate lane.
//   clock, reset : clock, asynchronous active-high reset
//   clear        : zero the accumulator (start of a new output)
//   enable       : accumulate (sample*coeff)>>>FRAC_BITS this cycle
//   sample/coeff : current tap operands (signed)
//   result       : output-width view of acc + this cycle's product, so the
//                  caller can register the final value on the last tap cycle
// Build option FIR_SAT_EN: result saturates from the full accumulator instead
// of wrapping to the low DATA_WIDTH bits.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COEFF_WIDTH = 32,
    parameter int unsigned FRAC_BITS   = 10,
    parameter int unsigned ACC_WIDTH   = 69
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  sample,
    input  logic [COEFF_WIDTH-1:0] coeff,
    output logic [DATA_WIDTH-1:0]  result
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc + ACC_WIDTH'(mul_frac(FIR_OPND_W'($signed(sample)),
                                             FIR_OPND_W'($signed(coeff)),
                                             FRAC_BITS));
`ifdef FIR_SAT_EN
        result = DATA_WIDTH'(sat(FIR_MAX_W'(acc_next), DATA_WIDTH));
`else
        result = acc_next[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_decim_mc.sv
// fir_decim_mc: multi-channel decimating FIR filter between two FIFOs.
//   clock, reset : clock, asynchronous active-high reset
//   in_dout      : NUM_CH packed samples (ch0 in LSBs) from upstream FIFO
//   in_empty     : upstream FIFO empty
//   in_rd_en     : pop upstream FIFO (combinational)
//   out_din      : NUM_CH packed filtered samples (registered)
//   out_wr_en    : push downstream FIFO (combinational)
//   out_full     : downstream FIFO full
// One output word per DECIMATION input words; one MAC lane per channel.
// Build option FIR_SAT_EN: saturate outputs instead of wrapping.
module fir_decim_mc
    import fir_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COEFF_WIDTH = 32,
    parameter int unsigned FRAC_BITS   = 10,
    parameter int unsigned TAP_NUMBER  = 32,
    parameter int unsigned DECIMATION  = 8,
    parameter logic [TAP_NUMBER-1:0][COEFF_WIDTH-1:0] COEFFS =
        (TAP_NUMBER*COEFF_WIDTH)'(1 << FRAC_BITS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_dout,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_din,
    output logic                         out_wr_en,
    input  logic                         out_full
);

    localparam int unsigned DEPTH  = TAP_NUMBER + DECIMATION;
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned KW     = (TAP_NUMBER > 1) ? $clog2(TAP_NUMBER) : 1;
    localparam int unsigned NW     = $clog2(DECIMATION + 1);
    localparam int unsigned ACC_W  = DATA_WIDTH + COEFF_WIDTH + $clog2(TAP_NUMBER);
    localparam int unsigned WW     = NUM_CH * DATA_WIDTH;

    fir_state_t       state, state_next;
    logic [WW-1:0]    hist [DEPTH];
    logic [PW-1:0]    wr_ptr, wr_ptr_next, base, base_next, rd_idx;
    logic [NW-1:0]    new_cnt, new_cnt_next;
    logic [KW-1:0]    tap_k;
    logic             pop, push, start_mac, last_tap, mac_en;
    logic [WW-1:0]    tap_word, lane_res;
    logic [COEFF_WIDTH-1:0] tap_coeff;

    always_comb begin
        // reset gating keeps both strobes low while reset is held
        pop          = !reset && !in_empty && (new_cnt < NW'(DECIMATION));
        push         = !reset && (state == WRITE) && !out_full;
        new_cnt_next = new_cnt + NW'(pop);
        wr_ptr_next  = wr_ptr;
        if (pop) begin
            wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
        // newest sample index, including a pop in this same cycle
        base_next = (wr_ptr_next == '0) ? PW'(DEPTH - 1) : wr_ptr_next - 1'b1;
        last_tap  = (tap_k == KW'(TAP_NUMBER - 1));
        mac_en    = (state == MAC);

        state_next = state;
        start_mac  = 1'b0;
        case (state)
            FILL: begin
                if (new_cnt_next == NW'(DECIMATION)) begin
                    state_next = MAC;
                    start_mac  = 1'b1;
                end
            end
            MAC: begin
                if (last_tap) state_next = WRITE;
            end
            WRITE: begin
                if (push) begin
                    if (new_cnt_next == NW'(DECIMATION)) begin
                        state_next = MAC;
                        start_mac  = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase

        // circular read of x[base-k]; depth exceeds taps so no live tap is overwritten
        rd_idx    = (base >= PW'(tap_k)) ? base - PW'(tap_k)
                                         : base + PW'(DEPTH) - PW'(tap_k);
        tap_word  = hist[rd_idx];
        tap_coeff = COEFFS[tap_k];

        in_rd_en  = pop;
        out_wr_en = push;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= FILL;
            wr_ptr  <= '0;
            new_cnt <= '0;
            base    <= '0;
            tap_k   <= '0;
            out_din <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
            if (pop) hist[wr_ptr] <= in_dout;
            new_cnt <= start_mac ? '0 : new_cnt_next;
            if (start_mac) begin
                base  <= base_next;
                tap_k <= '0;
            end else if (mac_en) begin
                tap_k <= tap_k + 1'b1;
            end
            if (mac_en && last_tap) out_din <= lane_res;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        fir_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .COEFF_WIDTH(COEFF_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_WIDTH  (ACC_W)
        ) u_lane (
            .clock (clock),
            .reset (reset),
            .clear (start_mac),
            .enable(mac_en),
            .sample(tap_word[c*DATA_WIDTH +: DATA_WIDTH]),
            .coeff (tap_coeff),
            .result(lane_res[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_fir_decim_mc.sv
// tb_fir_decim_mc: directed bench for fir_decim_mc.
// Main instance: 2 ch x 32 bit, 32 taps, decimate by 8, COEFFS[k] = 64*(k+1).
// Second instance: 2 ch x 16 bit, all coeffs 64 (gain 2.0), for wrap/saturation.
module tb_fir_decim_mc;

    localparam int unsigned TAPS = 32;
    localparam int unsigned CWD  = 32;

    function automatic logic [TAPS-1:0][CWD-1:0] make_coeffs();
        logic [TAPS-1:0][CWD-1:0] c;
        for (int k = 0; k < TAPS; k++) c[k] = CWD'(64 * (k + 1));
        return c;
    endfunction

    localparam logic [TAPS-1:0][CWD-1:0] TEST_COEFFS = make_coeffs();

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic [63:0] out_din;
    logic        out_wr_en;
    logic        out_full;

    logic [31:0] in_dout16   = 32'h7FFF7FFF;
    logic        in_empty16  = 1'b0;
    logic        in_rd_en16;
    logic [31:0] out_din16;
    logic        out_wr_en16;
    logic        out_full16  = 1'b0;

    always #5 clock = ~clock;

    fir_decim_mc #(
        .NUM_CH(2), .DATA_WIDTH(32), .COEFF_WIDTH(CWD), .FRAC_BITS(10),
        .TAP_NUMBER(TAPS), .DECIMATION(8), .COEFFS(TEST_COEFFS)
    ) u_dut (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_din(out_din), .out_wr_en(out_wr_en), .out_full(out_full)
    );

    fir_decim_mc #(
        .NUM_CH(2), .DATA_WIDTH(16), .COEFF_WIDTH(16), .FRAC_BITS(10),
        .TAP_NUMBER(32), .DECIMATION(8), .COEFFS({32{16'd64}})
    ) u_dut16 (
        .clock(clock), .reset(reset), .in_dout(in_dout16), .in_empty(in_empty16),
        .in_rd_en(in_rd_en16), .out_din(out_din16), .out_wr_en(out_wr_en16), .out_full(out_full16)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc, pops, pop8_cyc, viol, w16_cnt, pops16;
    logic [31:0] w16_val;
    logic        toggle_en;
    logic [7:0]  pat = 8'b1011_0010;
    logic [63:0] src_q[$];
    logic [63:0] wq[$];
    int          wcyc[$];

    task automatic drive();
        in_empty = (src_q.size() == 0) || (toggle_en && pat[cyc % 8]);
        in_dout  = (src_q.size() != 0) ? src_q[0] : 64'h0;
    endtask

    // one clock: observe at negedge, then update the source FIFO model after posedge
    task automatic tick();
        logic popped;
        @(negedge clock);
        cyc++;
        if (in_rd_en && in_empty) viol++;
        if (out_wr_en && out_full) viol++;
        popped = in_rd_en;
        if (in_rd_en) begin
            pops++;
            if (pops == 8) pop8_cyc = cyc;
        end
        if (out_wr_en) begin
            wq.push_back(out_din);
            wcyc.push_back(cyc);
        end
        if (in_rd_en16) pops16++;
        if (out_wr_en16) begin
            w16_cnt++;
            if (w16_cnt == 4) w16_val = out_din16;
        end
        @(posedge clock);
        #1;
        if (popped && src_q.size() > 0) void'(src_q.pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_q.delete();
        toggle_en = 1'b0;
        out_full  = 1'b0;
        drive();
        tick();
        tick();
        reset = 1'b0;
        wq.delete();
        wcyc.delete();
        pops = 0; pop8_cyc = -1; cyc = 0; viol = 0; w16_cnt = 0; pops16 = 0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int t = 0;
        while (wq.size() < n && t < budget) begin
            tick();
            t++;
        end
        checks++;
        if (wq.size() < n) begin
            errors++;
            $display("FAIL %s timeout: writes %0d required %0d", name, wq.size(), n);
        end
    endtask

    task automatic push_dc(input int n);
        logic [31:0] a, b;
        a = 32'd1000;
        b = 32'(-1000);
        for (int i = 0; i < n; i++) src_q.push_back({b, a});
        drive();
    endtask

    task automatic test_reset();
        src_q.push_back(64'h1);
        drive();
        tick();
        checks++;
        if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset in_rd_en got %b want 0", in_rd_en); end
        checks++;
        if (out_wr_en !== 1'b0) begin errors++; $display("FAIL reset out_wr_en got %b want 0", out_wr_en); end
        checks++;
        if (out_din !== 64'h0) begin errors++; $display("FAIL reset out_din got %h want 0", out_din); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_rd_en !== 1'b1) begin errors++; $display("FAIL reset_release in_rd_en got %b want 1", in_rd_en); end
    endtask

    task automatic test_impulse();
        int exp0[5] = '{64, 576, 1088, 1600, 0};
        logic [63:0] w;
        do_reset();
        for (int i = 0; i < 40; i++) src_q.push_back({32'h0, (i == 7) ? 32'd1024 : 32'd0});
        drive();
        wait_writes(5, 400, "impulse");
        repeat (40) tick();
        checks++;
        if (wq.size() != 5) begin errors++; $display("FAIL impulse count got %0d want 5", wq.size()); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            w = wq[i];
            checks++;
            if ($signed(w[31:0]) !== exp0[i]) begin
                errors++; $display("FAIL impulse[%0d] ch0 got %0d want %0d", i, $signed(w[31:0]), exp0[i]);
            end
            checks++;
            if (w[63:32] !== 32'h0) begin
                errors++; $display("FAIL impulse[%0d] ch1 got %0d want 0", i, $signed(w[63:32]));
            end
        end
        if (wcyc.size() >= 5) begin
            checks++;
            if (wcyc[0] - pop8_cyc != 33) begin
                errors++; $display("FAIL latency got %0d want 33", wcyc[0] - pop8_cyc);
            end
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (wcyc[i] - wcyc[i-1] != 33) begin
                    errors++; $display("FAIL throughput[%0d] gap got %0d want 33", i, wcyc[i] - wcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_dc();
        int exp0[6] = '{2248, 8496, 18744, 32992, 32992, 32992};
        int exp1[6] = '{-2252, -8504, -18756, -33008, -33008, -33008};
        logic [63:0] w;
        do_reset();
        push_dc(48);
        wait_writes(6, 500, "dc");
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            w = wq[i];
            checks++;
            if ($signed(w[31:0]) !== exp0[i]) begin
                errors++; $display("FAIL dc[%0d] ch0 got %0d want %0d", i, $signed(w[31:0]), exp0[i]);
            end
            checks++;
            if ($signed(w[63:32]) !== exp1[i]) begin
                errors++; $display("FAIL dc[%0d] ch1 got %0d want %0d", i, $signed(w[63:32]), exp1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp0[5] = '{2248, 8496, 18744, 32992, 32992};
        int exp1[5] = '{-2252, -8504, -18756, -33008, -33008};
        logic [63:0] w;
        do_reset();
        out_full = 1'b1;
        push_dc(40);
        repeat (150) tick();
        checks++;
        if (pops != 16) begin errors++; $display("FAIL stall pops got %0d want 16", pops); end
        checks++;
        if (wq.size() != 0) begin errors++; $display("FAIL stall writes got %0d want 0", wq.size()); end
        out_full = 1'b0;
        wait_writes(5, 400, "backpressure");
        repeat (40) tick();
        checks++;
        if (wq.size() != 5) begin errors++; $display("FAIL bp count got %0d want 5", wq.size()); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            w = wq[i];
            checks++;
            if ($signed(w[31:0]) !== exp0[i] || $signed(w[63:32]) !== exp1[i]) begin
                errors++; $display("FAIL bp[%0d] got %0d/%0d want %0d/%0d", i,
                                   $signed(w[31:0]), $signed(w[63:32]), exp0[i], exp1[i]);
            end
        end
        if (wcyc.size() >= 2) begin
            checks++;
            if (wcyc[1] - wcyc[0] != 33) begin
                errors++; $display("FAIL bp back_to_back gap got %0d want 33", wcyc[1] - wcyc[0]);
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bp protocol violations got %0d want 0", viol); end
    endtask

    task automatic test_empty_toggle();
        logic [63:0] w;
        do_reset();
        toggle_en = 1'b1;
        push_dc(64);
        wait_writes(8, 1500, "empty_toggle");
        repeat (100) tick();
        checks++;
        if (wq.size() != 8) begin errors++; $display("FAIL toggle count got %0d want 8", wq.size()); end
        for (int i = 3; i < 8 && i < wq.size(); i++) begin
            w = wq[i];
            checks++;
            if ($signed(w[31:0]) !== 32992 || $signed(w[63:32]) !== -33008) begin
                errors++; $display("FAIL toggle[%0d] got %0d/%0d want 32992/-33008", i,
                                   $signed(w[31:0]), $signed(w[63:32]));
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL toggle protocol violations got %0d want 0", viol); end
    endtask

    task automatic test_reset_mid_mac();
        logic [63:0] w;
        do_reset();
        push_dc(24);
        wait_writes(1, 200, "midreset_first");
        repeat (10) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (out_din !== 64'h0) begin errors++; $display("FAIL midreset out_din got %h want 0", out_din); end
        checks++;
        if (out_wr_en !== 1'b0 || in_rd_en !== 1'b0) begin
            errors++; $display("FAIL midreset strobes got %b%b want 00", out_wr_en, in_rd_en);
        end
        src_q.delete();
        drive();
        tick();
        tick();
        reset = 1'b0;
        repeat (60) tick();
        checks++;
        if (wq.size() != 1) begin errors++; $display("FAIL midreset writes got %0d want 1", wq.size()); end
        wq.delete();
        wcyc.delete();
        push_dc(8);
        wait_writes(1, 200, "midreset_fresh");
        if (wq.size() >= 1) begin
            w = wq[0];
            checks++;
            if ($signed(w[31:0]) !== 2248 || $signed(w[63:32]) !== -2252) begin
                errors++; $display("FAIL midreset fresh got %0d/%0d want 2248/-2252",
                                   $signed(w[31:0]), $signed(w[63:32]));
            end
        end
    endtask

    task automatic test_sat();
        logic [31:0] exp16;
        int t = 0;
`ifdef FIR_SAT_EN
        exp16 = 32'h7FFF7FFF;
`else
        exp16 = 32'hFFE0FFE0;
`endif
        do_reset();
        while (w16_cnt < 4 && t < 400) begin
            tick();
            t++;
        end
        checks++;
        if (w16_cnt < 4) begin
            errors++; $display("FAIL sat16 timeout: writes %0d required 4", w16_cnt);
        end else begin
            checks++;
            if (w16_val !== exp16) begin
                errors++; $display("FAIL sat16 got %h want %h", w16_val, exp16);
            end
        end
        checks++;
        if (pops16 < 32) begin errors++; $display("FAIL sat16 pops got %0d want >=32", pops16); end
    endtask

    initial begin
        toggle_en = 1'b0;
        out_full  = 1'b0;
        cyc = 0; pops = 0; pop8_cyc = -1; viol = 0; w16_cnt = 0; pops16 = 0;
        w16_val = 32'h0;
        drive();
        test_reset();
        test_impulse();
        test_dc();
        test_backpressure();
        test_empty_toggle();
        test_reset_mid_mac();
        test_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
